// File: rtl/rename_types_pkg.sv
// Shared types and sizing for the register rename stage and its free list.
package rename_types_pkg;
    localparam int ARCH_REGS = 32;
    localparam int PHYS_REGS = 64;
    localparam int PREG_W    = $clog2(PHYS_REGS);
    localparam int AREG_W    = $clog2(ARCH_REGS);
    localparam int FREE_REGS = PHYS_REGS - ARCH_REGS;
    localparam int COUNT_W   = $clog2(FREE_REGS + 1);
    localparam int PAYLOAD_W = 16;

    typedef logic [PREG_W-1:0] preg_t;
    typedef logic [AREG_W-1:0] areg_t;

    typedef struct packed {
        areg_t                rs1;
        areg_t                rs2;
        areg_t                rd;
        logic                 has_rd;
        logic [PAYLOAD_W-1:0] payload;
    } decoded_t;

    typedef struct packed {
        preg_t                prs1;
        preg_t                prs2;
        preg_t                prd;
        preg_t                old_prd;
        logic                 has_rd;
        logic [PAYLOAD_W-1:0] payload;
    } renamed_t;
endpackage

// File: rtl/rename_stage_free_list.sv
// Circular FIFO of unallocated physical registers; head is the next preg handed out.
module free_list
    import rename_types_pkg::*;
#(
    parameter int DEPTH = FREE_REGS
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               alloc,
    input  logic               free_valid,
    input  preg_t              free_preg,
    output preg_t              head_preg,
    output logic [COUNT_W-1:0] count
);
    localparam int PTR_W = $clog2(DEPTH);

    preg_t            mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic             push;
    logic             pop;

    // preg 0 backs x0 permanently, so releasing it is a no-op.
    assign push      = free_valid && (free_preg != '0);
    assign pop       = alloc && (count != '0);
    assign head_preg = mem[head];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= preg_t'(ARCH_REGS + i);
            end
            head  <= '0;
            tail  <= '0;
            count <= COUNT_W'(DEPTH);
        end else begin
            if (push) begin
                mem[tail] <= free_preg;
                tail      <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            count <= count + COUNT_W'(push) - COUNT_W'(pop);
        end
    end

    overflow_a: assert property (@(posedge clk) disable iff (reset)
        !(push && count == COUNT_W'(DEPTH)));
endmodule

// File: rtl/rename_stage.sv
// Register rename: map table lookup, preg allocation from the free list, registered output.
module rename_stage
    import rename_types_pkg::*;
#(
    parameter int ARCH_REGS = rename_types_pkg::ARCH_REGS,
    parameter int PHYS_REGS = rename_types_pkg::PHYS_REGS
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               valid_in,
    output logic               ready_in,
    input  decoded_t           data_in,
    output logic               valid_out,
    input  logic               ready_out,
    output renamed_t           data_out,
    input  logic               free_valid,
    input  preg_t              free_preg,
    output logic [COUNT_W-1:0] free_count
);
    // Handshake: a beat moves when valid and ready are both high on a rising edge;
    // valid never waits on ready, and held data stays stable until it is taken.
    preg_t    map_q [ARCH_REGS];
    preg_t    head_preg;
    logic     alloc_needed;
    logic     xfer;
    renamed_t renamed;

    assign alloc_needed = data_in.has_rd && (data_in.rd != '0);
    assign ready_in     = (ready_out || !valid_out) && ((free_count != '0) || !alloc_needed);
    assign xfer         = valid_in && ready_in;

    // Entry 0 is never stored; x0 reads as preg 0. Reads see the pre-write map.
    always_comb begin
        renamed         = '0;
        renamed.prs1    = (data_in.rs1 == '0) ? '0 : map_q[data_in.rs1];
        renamed.prs2    = (data_in.rs2 == '0) ? '0 : map_q[data_in.rs2];
        renamed.prd     = alloc_needed ? head_preg : '0;
        renamed.old_prd = alloc_needed ? map_q[data_in.rd] : '0;
        renamed.has_rd  = data_in.has_rd;
        renamed.payload = data_in.payload;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 1; i < ARCH_REGS; i++) begin
                map_q[i] <= preg_t'(i);
            end
        end else if (xfer && alloc_needed) begin
            map_q[data_in.rd] <= head_preg;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_out <= 1'b0;
            data_out  <= '0;
        end else if (xfer) begin
            valid_out <= 1'b1;
            data_out  <= renamed;
        end else if (ready_out) begin
            valid_out <= 1'b0;
        end
    end

    free_list #(
        .DEPTH(PHYS_REGS - ARCH_REGS)
    ) u_free_list (
        .clk       (clk),
        .reset     (reset),
        .alloc     (xfer && alloc_needed),
        .free_valid(free_valid),
        .free_preg (free_preg),
        .head_preg (head_preg),
        .count     (free_count)
    );
endmodule

// File: tb/tb_rename_stage.sv
// Bench for rename_stage: directed scenarios plus random traffic against a queue-based model.
module tb_rename_stage;
    import rename_types_pkg::*;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               valid_in = 1'b0;
    logic               ready_out = 1'b1;
    logic               free_valid = 1'b0;
    decoded_t           data_in = '0;
    preg_t              free_preg = '0;
    logic               ready_in;
    logic               valid_out;
    renamed_t           data_out;
    logic [COUNT_W-1:0] free_count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    rename_stage dut (
        .clk       (clk),
        .reset     (reset),
        .valid_in  (valid_in),
        .ready_in  (ready_in),
        .data_in   (data_in),
        .valid_out (valid_out),
        .ready_out (ready_out),
        .data_out  (data_out),
        .free_valid(free_valid),
        .free_preg (free_preg),
        .free_count(free_count)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: architectural map array plus a queue of free pregs.
    preg_t    m_map [ARCH_REGS];
    preg_t    free_q [$];
    logic     m_valid = 1'b0;
    renamed_t m_data = '0;
    bit       m_init = 1'b0;
    bit       m_xfer;
    renamed_t m_r;

    function automatic bit m_alloc(input decoded_t d);
        return d.has_rd && (d.rd != 0);
    endfunction

    function automatic logic m_ready();
        return (ready_out || !m_valid) && (free_q.size() != 0 || !m_alloc(data_in));
    endfunction

    always @(posedge clk) begin : model
        if (reset) begin
            for (int i = 0; i < ARCH_REGS; i++) m_map[i] = preg_t'(i);
            free_q.delete();
            for (int i = 0; i < FREE_REGS; i++) free_q.push_back(preg_t'(ARCH_REGS + i));
            m_valid = 1'b0;
            m_data  = '0;
            m_init  = 1'b1;
        end else if (m_init) begin
            m_xfer = valid_in && m_ready();
            m_r    = '0;
            if (m_xfer) begin
                m_r.prs1    = m_map[data_in.rs1];
                m_r.prs2    = m_map[data_in.rs2];
                m_r.has_rd  = data_in.has_rd;
                m_r.payload = data_in.payload;
                if (m_alloc(data_in)) begin
                    m_r.prd            = free_q.pop_front();
                    m_r.old_prd        = m_map[data_in.rd];
                    m_map[data_in.rd]  = m_r.prd;
                end
            end
            if (free_valid && free_preg != 0) free_q.push_back(free_preg);
            if (m_xfer) begin
                m_valid = 1'b1;
                m_data  = m_r;
            end else if (ready_out) begin
                m_valid = 1'b0;
            end
        end
    end

    always @(negedge clk) begin : compare
        if (m_init) begin
            check("ready_in", 64'(ready_in), 64'(m_ready()));
            check("valid_out", 64'(valid_out), 64'(m_valid));
            check("free_count", 64'(free_count), 64'(free_q.size()));
            check("data_out", 64'(data_out), 64'(m_data));
        end
    end

    logic [PAYLOAD_W-1:0] last_payload;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input int rs1, input int rs2, input int rd, input bit has_rd);
        valid_in        = v;
        data_in.rs1     = areg_t'(rs1);
        data_in.rs2     = areg_t'(rs2);
        data_in.rd      = areg_t'(rd);
        data_in.has_rd  = has_rd;
        last_payload    = PAYLOAD_W'($urandom);
        data_in.payload = last_payload;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        valid_in = 1'b0;
        free_valid = 1'b0;
        ready_out = 1'b1;
        step();
        reset = 1'b0;
    endtask

    renamed_t held;

    initial begin
        // Reset state
        step();
        step();
        check("rst_valid_out", 64'(valid_out), 64'd0);
        check("rst_free_count", 64'(free_count), 64'd32);
        check("rst_data_out", 64'(data_out), 64'd0);
        check("rst_ready_in", 64'(ready_in), 64'd1);
        reset = 1'b0;

        // Single instruction reading its own destination
        drive(1, 5, 6, 5, 1);
        step();
        check("first_prs1", 64'(data_out.prs1), 64'd5);
        check("first_prs2", 64'(data_out.prs2), 64'd6);
        check("first_prd", 64'(data_out.prd), 64'd32);
        check("first_old_prd", 64'(data_out.old_prd), 64'd5);
        check("first_count", 64'(free_count), 64'd31);
        drive(1, 5, 0, 0, 0);
        step();
        check("second_prs1", 64'(data_out.prs1), 64'd32);
        check("second_prd", 64'(data_out.prd), 64'd0);
        valid_in = 1'b0;
        step();

        // Drain the free list with 32 back-to-back allocations
        do_reset();
        for (int i = 0; i < 32; i++) begin
            drive(1, $urandom_range(0, 31), $urandom_range(0, 31), (i % 31) + 1, 1);
            step();
            check("drain_prd", 64'(data_out.prd), 64'(32 + i));
        end
        check("drain_count", 64'(free_count), 64'd0);
        drive(1, 1, 2, 7, 1);
        #1;
        check("drain_stall", 64'(ready_in), 64'd0);

        // A free into an empty list does not bypass to the waiting allocation
        drive(1, 0, 0, 3, 1);
        free_valid = 1'b1;
        free_preg  = 6'd7;
        #1;
        check("nobypass_ready", 64'(ready_in), 64'd0);
        step();
        free_valid = 1'b0;
        #1;
        check("refill_ready", 64'(ready_in), 64'd1);
        check("refill_count", 64'(free_count), 64'd1);
        step();
        check("refill_prd", 64'(data_out.prd), 64'd7);
        check("refill_old_prd", 64'(data_out.old_prd), 64'd34);
        check("refill_count0", 64'(free_count), 64'd0);

        // Non-allocating instructions pass with an empty free list
        drive(1, 3, 0, 0, 1);
        #1;
        check("x0_ready", 64'(ready_in), 64'd1);
        step();
        check("x0_prd", 64'(data_out.prd), 64'd0);
        check("x0_old_prd", 64'(data_out.old_prd), 64'd0);
        check("x0_prs1", 64'(data_out.prs1), 64'd7);
        drive(1, 9, 0, 9, 0);
        step();
        check("nord_prd", 64'(data_out.prd), 64'd0);
        check("nord_prs1", 64'(data_out.prs1), 64'd40);
        drive(1, 9, 0, 0, 0);
        step();
        check("nord_map_kept", 64'(data_out.prs1), 64'd40);
        check("nord_count", 64'(free_count), 64'd0);

        // Downstream backpressure holds the output and freezes rename state
        do_reset();
        drive(1, 1, 2, 4, 1);
        step();
        held = '{prs1: 6'd1, prs2: 6'd2, prd: 6'd32, old_prd: 6'd4, has_rd: 1'b1, payload: last_payload};
        check("bp_first", 64'(data_out), 64'(held));
        ready_out = 1'b0;
        drive(1, 4, 0, 6, 1);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_ready", 64'(ready_in), 64'd0);
            step();
            check("bp_hold", 64'(data_out), 64'(held));
            check("bp_valid", 64'(valid_out), 64'd1);
            check("bp_count", 64'(free_count), 64'd31);
        end
        ready_out = 1'b1;
        #1;
        check("bp_release_ready", 64'(ready_in), 64'd1);
        step();
        check("bp_release_prd", 64'(data_out.prd), 64'd33);
        check("bp_release_prs1", 64'(data_out.prs1), 64'd32);
        check("bp_release_old", 64'(data_out.old_prd), 64'd6);

        // Reset in the middle of a stream
        do_reset();
        for (int i = 0; i < 10; i++) begin
            drive(1, 0, 0, i + 1, 1);
            step();
        end
        check("mid_count", 64'(free_count), 64'd22);
        drive(1, 2, 3, 11, 1);
        free_valid = 1'b1;
        free_preg  = 6'd9;
        reset      = 1'b1;
        step();
        check("mid_rst_valid", 64'(valid_out), 64'd0);
        check("mid_rst_count", 64'(free_count), 64'd32);
        check("mid_rst_data", 64'(data_out), 64'd0);
        reset      = 1'b0;
        free_valid = 1'b0;
        drive(1, 5, 3, 5, 1);
        step();
        check("mid_prd", 64'(data_out.prd), 64'd32);
        check("mid_prs1", 64'(data_out.prs1), 64'd5);
        check("mid_prs2", 64'(data_out.prs2), 64'd3);
        check("mid_old", 64'(data_out.old_prd), 64'd5);

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(0, 299) == 0);
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 31), $urandom_range(0, 31),
                  $urandom_range(0, 31), $urandom_range(0, 4) != 0);
            ready_out = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 2) == 0) begin
                free_valid = 1'b1;
                free_preg  = (free_q.size() < FREE_REGS) ? preg_t'($urandom_range(0, 63)) : '0;
            end else begin
                free_valid = 1'b0;
            end
            step();
        end
        reset = 1'b0;
        valid_in = 1'b0;
        free_valid = 1'b0;
        step();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
